// File: rtl/fir_link_pkg.sv
// fir_link_pkg: constants and state encoding shared by the FIR UART link
// host controller and its byte sender.
//   BYTE_W             - width of one UART byte
//   SAMPLE_W           - width of a sample / FIR result (two bytes)
//   TIMEOUT_CYCLES_DEF - default receive timeout in clk cycles
//   state_t            - 3-bit host controller state encoding
package fir_link_pkg;

  localparam int BYTE_W             = 8;
  localparam int SAMPLE_W           = 16;
  localparam int TIMEOUT_CYCLES_DEF = 1048576;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SEND_MSB = 3'd1,
    WAIT_MSB = 3'd2,
    SEND_LSB = 3'd3,
    WAIT_LSB = 3'd4,
    RECV_MSB = 3'd5,
    RECV_LSB = 3'd6,
    PRESENT  = 3'd7
  } state_t;

endpackage

// File: rtl/fir_uart_byte_sender.sv
// fir_uart_byte_sender: issues one byte to a UART transmitter.
// The owner raises 'send' while it wants a byte started and 'hold' while it
// waits for that byte to finish. The start pulse is issued as soon as the
// transmitter is idle; the cycle right after the pulse ignores TxD_busy,
// because the transmitter only raises busy one cycle late.
// Ports:
//   clk, reset        - clock, synchronous active-high reset
//   send              - owner is in a SEND_* state
//   hold              - owner is in a WAIT_* state
//   data              - byte to send (sampled on the start cycle)
//   TxD_busy          - transmitter busy
//   fire              - start is being issued this cycle (combinational)
//   done              - byte finished, owner may move on (combinational)
//   TxD_start         - registered one-cycle start pulse
//   TxD_data          - registered byte, stable until the next start
module fir_uart_byte_sender
  import fir_link_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              send,
  input  logic              hold,
  input  logic [BYTE_W-1:0] data,
  input  logic              TxD_busy,
  output logic              fire,
  output logic              done,
  output logic              TxD_start,
  output logic [BYTE_W-1:0] TxD_data
);

  // Set on the start pulse, cleared after the first wait cycle.
  logic blank;

  assign fire = send && !TxD_busy;
  assign done = hold && !blank && !TxD_busy;

  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      TxD_start <= 1'b0;
      TxD_data  <= '0;
      blank     <= 1'b0;
    end else begin
      TxD_start <= fire;
      if (fire) begin
        TxD_data <= data;
        blank    <= 1'b1;
      end else if (hold) begin
        blank <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/fir_uart_host_ctrl.sv
// fir_uart_host_ctrl: host side of the FIR board UART link. Sends each
// 16-bit sample as two UART bytes (MSB first), then collects the two-byte
// FIR result (MSB first) and presents it on a valid/ready port.
// Optional feature: define FIR_HOST_TIMEOUT_EN to abort a receive that
// stalls for TIMEOUT_CYCLES clocks (sets link_error, returns to IDLE).
// Ports:
//   clk, reset                    - clock, synchronous active-high reset
//   sample_in/valid/ready         - sample input handshake
//   TxD_start, TxD_data, TxD_busy - UART transmitter interface
//   RxD_data_ready, RxD_data      - UART receiver interface
//   result_out/valid/ready        - result output handshake
//   link_error                    - sticky error (stray byte or timeout)
//   tx_count                      - samples sent, wraps at 16 bits
module fir_uart_host_ctrl
  import fir_link_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int TO_W           = 21
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [SAMPLE_W-1:0] sample_in,
  input  logic                sample_valid,
  output logic                sample_ready,
  output logic                TxD_start,
  output logic [BYTE_W-1:0]   TxD_data,
  input  logic                TxD_busy,
  input  logic                RxD_data_ready,
  input  logic [BYTE_W-1:0]   RxD_data,
  output logic [SAMPLE_W-1:0] result_out,
  output logic                result_valid,
  input  logic                result_ready,
  output logic                link_error,
  output logic [15:0]         tx_count
);

  if ((64'd1 << TO_W) <= 64'(TIMEOUT_CYCLES)) begin : g_bad_to_w
    $error("TO_W is too narrow to count to TIMEOUT_CYCLES");
  end

  state_t              state;
  logic [SAMPLE_W-1:0] sample;
  logic                send, hold, fire, done, in_recv, stray;
  logic [BYTE_W-1:0]   tx_byte;

  assign send    = (state == SEND_MSB) || (state == SEND_LSB);
  assign hold    = (state == WAIT_MSB) || (state == WAIT_LSB);
  assign in_recv = (state == RECV_MSB) || (state == RECV_LSB);
  assign stray   = RxD_data_ready && !in_recv;
  assign tx_byte = (state == SEND_MSB) ? sample[15:8] : sample[7:0];

  fir_uart_byte_sender u_sender (
    .clk       (clk),
    .reset     (reset),
    .send      (send),
    .hold      (hold),
    .data      (tx_byte),
    .TxD_busy  (TxD_busy),
    .fire      (fire),
    .done      (done),
    .TxD_start (TxD_start),
    .TxD_data  (TxD_data)
  );

`ifdef FIR_HOST_TIMEOUT_EN
  logic [TO_W-1:0] to_cnt;
  logic            to_hit;

  assign to_hit = (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  // Held at zero outside the receive states, so entering RECV_MSB starts
  // from zero; every received byte restarts the count.
  always_ff @(posedge clk) begin
    if (reset || !in_recv || RxD_data_ready) to_cnt <= '0;
    else                                     to_cnt <= to_cnt + 1'b1;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      sample       <= '0;
      sample_ready <= 1'b0;
      result_out   <= '0;
      result_valid <= 1'b0;
      link_error   <= 1'b0;
      tx_count     <= '0;
    end else begin
      // Bytes arriving outside a receive state are dropped but flagged.
      if (stray) link_error <= 1'b1;

      case (state)
        IDLE: begin
          // sample_ready rises one cycle after entering IDLE, giving the
          // one-cycle turnaround after a result or reset.
          if (sample_valid && sample_ready) begin
            sample       <= sample_in;
            sample_ready <= 1'b0;
            state        <= SEND_MSB;
          end else begin
            sample_ready <= 1'b1;
          end
        end
        SEND_MSB: if (fire) state <= WAIT_MSB;
        WAIT_MSB: if (done) state <= SEND_LSB;
        SEND_LSB: if (fire) state <= WAIT_LSB;
        WAIT_LSB: begin
          if (done) begin
            tx_count <= tx_count + 1'b1;
            state    <= RECV_MSB;
          end
        end
        RECV_MSB: begin
          if (RxD_data_ready) begin
            result_out[15:8] <= RxD_data;
            state            <= RECV_LSB;
          end
`ifdef FIR_HOST_TIMEOUT_EN
          else if (to_hit) begin
            link_error <= 1'b1;
            result_out <= '0;
            state      <= IDLE;
          end
`endif
        end
        RECV_LSB: begin
          if (RxD_data_ready) begin
            result_out[7:0] <= RxD_data;
            result_valid    <= 1'b1;
            state           <= PRESENT;
          end
`ifdef FIR_HOST_TIMEOUT_EN
          else if (to_hit) begin
            link_error <= 1'b1;
            result_out <= '0;
            state      <= IDLE;
          end
`endif
        end
        PRESENT: begin
          if (result_ready) begin
            result_valid <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_uart_host_ctrl.sv
// tb_fir_uart_host_ctrl: scoreboard bench for fir_uart_host_ctrl.
// Stimulus pushes expected TxD bytes and results into queues; monitors pop
// and compare whenever the DUT issues TxD_start or completes a result
// handshake. A small UART model raises TxD_busy one cycle after each start
// for 10 cycles. Inputs change 1 ns after posedge; outputs are sampled on
// negedge.
module tb_fir_uart_host_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] sample_in = '0;
  logic        sample_valid = 1'b0;
  logic        sample_ready;
  logic        TxD_start;
  logic [7:0]  TxD_data;
  logic        TxD_busy = 1'b0;
  logic        RxD_data_ready = 1'b0;
  logic [7:0]  RxD_data = '0;
  logic [15:0] result_out;
  logic        result_valid;
  logic        result_ready = 1'b1;
  logic        link_error;
  logic [15:0] tx_count;

  always #5 clk = ~clk;

  fir_uart_host_ctrl #(.TIMEOUT_CYCLES(100), .TO_W(21)) dut (
    .clk            (clk),
    .reset          (reset),
    .sample_in      (sample_in),
    .sample_valid   (sample_valid),
    .sample_ready   (sample_ready),
    .TxD_start      (TxD_start),
    .TxD_data       (TxD_data),
    .TxD_busy       (TxD_busy),
    .RxD_data_ready (RxD_data_ready),
    .RxD_data       (RxD_data),
    .result_out     (result_out),
    .result_valid   (result_valid),
    .result_ready   (result_ready),
    .link_error     (link_error),
    .tx_count       (tx_count)
  );

  int          n_cmp = 0;
  int          n_err = 0;
  int          n_starts = 0;
  int          base = 0;
  logic [7:0]  exp_tx[$];
  logic [15:0] exp_res[$];
  logic        force_busy = 1'b0;
  int          tx_left = 0;
  logic        prev_start = 1'b0;
  logic        bp_ok;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // UART transmitter model: busy rises the cycle after a start pulse.
  initial forever begin
    tick();
    TxD_busy = force_busy || (tx_left > 0);
    if (TxD_start)        tx_left = 10;
    else if (tx_left > 0) tx_left--;
  end

  // TxD monitor.
  initial forever begin
    @(negedge clk);
    if (!reset && TxD_start) begin
      n_starts++;
      check("tx_double_start", 32'(prev_start), 0);
      check("tx_start_expected", 32'(exp_tx.size() != 0), 1);
      if (exp_tx.size() != 0) check("tx_byte", 32'(TxD_data), 32'(exp_tx.pop_front()));
    end
    prev_start = TxD_start;
  end

  // Result monitor.
  initial forever begin
    @(negedge clk);
    if (!reset && result_valid && result_ready) begin
      check("result_expected", 32'(exp_res.size() != 0), 1);
      if (exp_res.size() != 0) check("result_out", 32'(result_out), 32'(exp_res.pop_front()));
    end
  end

  task automatic send_sample(input logic [15:0] s);
    tick();
    sample_in    = s;
    sample_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (sample_ready) begin
        exp_tx.push_back(s[15:8]);
        exp_tx.push_back(s[7:0]);
        tick();
        sample_valid = 1'b0;
        return;
      end
      tick();
    end
    check("sample_accept", 32'(sample_ready), 1);
    sample_valid = 1'b0;
  endtask

  task automatic wait_starts(input int target);
    for (int i = 0; i < 300; i++) begin
      if (n_starts >= target) return;
      @(negedge clk);
    end
    check("tx_start_seen", n_starts, target);
  endtask

  // Wait until both bytes are out and the DUT sits in RECV_MSB.
  task automatic wait_tx_idle(input int target);
    wait_starts(target);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!TxD_busy && !TxD_start) begin
        repeat (2) @(negedge clk);
        return;
      end
    end
    check("tx_busy_release", 32'(TxD_busy), 0);
  endtask

  task automatic send_rx(input logic [7:0] b);
    tick();
    RxD_data       = b;
    RxD_data_ready = 1'b1;
    tick();
    RxD_data_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) tick();
    @(negedge clk);
    check("rst_sample_ready", 32'(sample_ready), 0);
    check("rst_txd_start", 32'(TxD_start), 0);
    check("rst_txd_data", 32'(TxD_data), 0);
    check("rst_result_out", 32'(result_out), 0);
    check("rst_result_valid", 32'(result_valid), 0);
    check("rst_link_error", 32'(link_error), 0);
    check("rst_tx_count", 32'(tx_count), 0);
    tick();
    reset = 1'b0;

    // Basic transfer.
    send_sample(16'h1234);
    wait_tx_idle(2);
    check("t1_tx_drained", exp_tx.size(), 0);
    exp_res.push_back(16'hABCD);
    send_rx(8'hAB);
    @(negedge clk);
    check("t1_no_early_valid", 32'(result_valid), 0);
    send_rx(8'hCD);
    @(negedge clk);
    check("t1_valid_latency", 32'(result_valid), 1);
    @(negedge clk);
    check("t1_valid_dropped", 32'(result_valid), 0);
    check("t1_tx_count", 32'(tx_count), 1);
    check("t1_link_error", 32'(link_error), 0);

    // Busy already high, then result backpressure.
    base = n_starts;
    force_busy = 1'b1;
    send_sample(16'hBEEF);
    repeat (5) tick();
    check("t2_no_start_while_busy", n_starts, base);
    force_busy = 1'b0;
    result_ready = 1'b0;
    wait_tx_idle(base + 2);
    check("t2_tx_drained", exp_tx.size(), 0);
    exp_res.push_back(16'hABCD);
    send_rx(8'hAB);
    send_rx(8'hCD);
    bp_ok = 1'b1;
    tick();
    sample_in    = 16'h9999;
    sample_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!(result_valid === 1'b1 && result_out === 16'hABCD && sample_ready === 1'b0))
        bp_ok = 1'b0;
    end
    check("t3_backpressure_stable", 32'(bp_ok), 1);
    tick();
    sample_valid = 1'b0;
    check("t3_no_extra_start", n_starts, base + 2);
    check("t3_tx_count", 32'(tx_count), 2);
    tick();
    result_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("t3_valid_dropped", 32'(result_valid), 0);
    check("t3_turnaround_idle", 32'(sample_ready), 0);
    @(negedge clk);
    check("t3_ready_after_turnaround", 32'(sample_ready), 1);

    // Stray byte during WAIT_MSB.
    base = n_starts;
    send_sample(16'h5A5A);
    wait_starts(base + 1);
    repeat (2) @(negedge clk);
    send_rx(8'h55);
    @(negedge clk);
    check("t4_link_error_set", 32'(link_error), 1);
    check("t4_result_unchanged", 32'(result_out), 32'h0000ABCD);
    wait_tx_idle(base + 2);
    check("t4_tx_drained", exp_tx.size(), 0);
    exp_res.push_back(16'h0FF0);
    send_rx(8'h0F);
    send_rx(8'hF0);
    @(negedge clk);
    check("t4_result_valid", 32'(result_valid), 1);
    check("t4_result_value", 32'(result_out), 32'h00000FF0);
    @(negedge clk);
    check("t4_tx_count", 32'(tx_count), 3);
    check("t4_link_error_sticky", 32'(link_error), 1);

    // Reset during WAIT_LSB.
    base = n_starts;
    send_sample(16'h7788);
    wait_starts(base + 2);
    repeat (2) @(negedge clk);
    tick();
    reset = 1'b1;
    exp_tx.delete();
    exp_res.delete();
    tick();
    @(negedge clk);
    check("t5_rst_sample_ready", 32'(sample_ready), 0);
    check("t5_rst_txd_start", 32'(TxD_start), 0);
    check("t5_rst_txd_data", 32'(TxD_data), 0);
    check("t5_rst_result_out", 32'(result_out), 0);
    check("t5_rst_result_valid", 32'(result_valid), 0);
    check("t5_rst_link_error", 32'(link_error), 0);
    check("t5_rst_tx_count", 32'(tx_count), 0);
    tick();
    reset = 1'b0;
    base = n_starts;
    send_sample(16'h00FF);
    wait_tx_idle(base + 2);
    check("t5_tx_drained", exp_tx.size(), 0);
    exp_res.push_back(16'h1234);
    send_rx(8'h12);
    send_rx(8'h34);
    @(negedge clk);
    @(negedge clk);
    check("t5_tx_count", 32'(tx_count), 1);
    check("t5_link_error", 32'(link_error), 0);

`ifdef FIR_HOST_TIMEOUT_EN
    // Receive timeout: only the MSB is returned.
    base = n_starts;
    send_sample(16'h4321);
    wait_tx_idle(base + 2);
    send_rx(8'h43);
    for (int j = 0; j <= 101; j++) begin
      @(negedge clk);
      if (j == 99)  check("t6_no_early_timeout", 32'(link_error), 0);
      if (j == 100) check("t6_timeout_error", 32'(link_error), 1);
      if (j == 101) check("t6_back_to_idle", 32'(sample_ready), 1);
    end
    check("t6_no_result_valid", 32'(result_valid), 0);
`endif

    repeat (2) tick();
    check("end_result_queue_empty", exp_res.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
